lfsr_range_gen: RTL and testbench
=================================

LFSR_RANGE_GEN -- requirements
Module: lfsr_range_gen

Interface
REQ-001 Parameter WIDTH, default 16: LFSR state width.
REQ-002 Parameter OUT_W, default 8: result width; OUT_W SHALL be <= WIDTH.
REQ-003 Parameter TAPS, default 16'hB400: Galois feedback mask (x^16+x^14+x^13+x^11+1).
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 seed  input  WIDTH  LFSR value loaded on reset or load_seed.
REQ-007 load_seed  input  1  request to reload the LFSR from seed.
REQ-008 start  input  1  request one random draw.
REQ-009 bound  input  OUT_W  exclusive upper limit of the result; sampled with start.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 out_valid  output  1  out_data holds an accepted result.
REQ-012 out_data  output  OUT_W  result in [0, bound-1].
REQ-013 busy  output  1  high in DRAW and HOLD.
REQ-014 lfsr_state  output  WIDTH  current LFSR register value.

Function
REQ-015 next(s) SHALL equal (s >> 1) XOR (s[0] ? TAPS : 0).
REQ-016 Any load of seed equal to 0 SHALL write 1 instead, so the LFSR never locks up at zero.
REQ-017 FSM states SHALL be IDLE, DRAW and HOLD.
REQ-018 IDLE: start=1 with bound!=0 SHALL latch bound and mask, then go to DRAW.
REQ-018a IDLE: start=1 with bound==0 SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-019 mask SHALL be all ones up to and including the highest set bit of (bound-1); mask=0 when bound=1.
REQ-020 In each DRAW cycle the LFSR SHALL step once, to lfsr_state <= next(lfsr_state).
REQ-020a In each DRAW cycle, candidate SHALL be next(lfsr_state)[OUT_W-1:0] & mask.
REQ-021 In DRAW, candidate < latched bound SHALL set out_data <= candidate and out_valid <= 1, then go to HOLD.
REQ-021a In DRAW, any other candidate SHALL be rejected and the FSM SHALL stay in DRAW.
REQ-022 Minimum latency: out_valid SHALL be high in the cycle after the first DRAW cycle, i.e. 2 edges after start is sampled.
REQ-023 In HOLD the LFSR SHALL NOT step, and out_data and out_valid SHALL stay stable until out_ready=1.
REQ-024 In HOLD, out_valid=1 and out_ready=1 at an edge SHALL clear out_valid and return the FSM to IDLE.
REQ-024a out_data SHALL retain its last value after the transfer.
REQ-025 start asserted in DRAW or HOLD SHALL be ignored and not queued.
REQ-025a A new start SHALL be honoured only in IDLE, earliest the cycle after the handshake.
REQ-026 load_seed SHALL be honoured only in IDLE and ignored in DRAW and HOLD.
REQ-026a load_seed and start together in IDLE: the seed SHALL load, start SHALL be ignored, and the FSM SHALL stay in IDLE.
REQ-027 The LFSR SHALL NOT step in IDLE.
REQ-028 busy SHALL be 1 exactly when the state is DRAW or HOLD.

Reset
REQ-029 reset=1 at an edge SHALL override every other input.
REQ-029a On that edge: state=IDLE, out_valid=0, out_data=0, busy=0, lfsr_state=seed (0 replaced by 1).
REQ-030 reset asserted in DRAW or HOLD SHALL abort the draw, and no out_valid SHALL follow.

Verification
REQ-031 reset with seed=16'h0000 -> lfsr_state=16'h0001, out_valid=0, busy=0.
REQ-032 seed=16'hACE1, start with bound=8 -> lfsr_state=16'hE270 after one DRAW cycle; out_valid=1, out_data=0 two edges after start.
REQ-033 seed=16'h0006, start with bound=3 -> draw 1 gives candidate 3 (rejected, LFSR=16'h0003); draw 2 gives 1 (LFSR=16'hB401); out_data=1, out_valid at edge 3.
REQ-034 bound=0 with start -> busy stays 0, lfsr_state unchanged.
REQ-034a bound=1 -> out_data=0 after the first draw.
REQ-035 out_ready held 0 for 5 cycles in HOLD -> out_data and lfsr_state stable, and start pulses ignored.
REQ-035a out_ready=1 -> out_valid drops the next edge and the FSM is back in IDLE.
REQ-036 reset pulsed mid-DRAW with seed=16'h1234 -> lfsr_state=16'h1234, IDLE, out_valid never asserted.
REQ-036a load_seed in IDLE -> lfsr_state=seed the next cycle; load_seed in HOLD -> no effect.

Source files
------------

// File: rtl/lfsr_range_gen.sv
// Galois LFSR random-number source returning a value in [0, bound-1] by
// mask-and-reject sampling, with a valid/ready result hold stage.
module lfsr_range_gen #(
  parameter int              WIDTH = 16,
  parameter int              OUT_W = 8,
  parameter logic [WIDTH-1:0] TAPS = 16'hB400
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] seed,
  input  logic             load_seed,
  input  logic             start,
  input  logic [OUT_W-1:0] bound,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             busy,
  output logic [WIDTH-1:0] lfsr_state,
  output logic [1:0]       fsm_state
);

  // Handshake: a result transfers on an edge where out_valid=1 and
  // out_ready=1; out_data/out_valid are held unchanged until then.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] bound_q, bound_d;
  logic [OUT_W-1:0] mask_q, mask_d;

  logic [WIDTH-1:0] lfsr_nxt;
  logic [WIDTH-1:0] seed_fix;
  logic [OUT_W-1:0] bound_m1;
  logic [OUT_W-1:0] new_mask;
  logic [OUT_W-1:0] candidate;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  // A zero seed would lock the LFSR, so it is replaced by 1.
  assign seed_fix  = (seed == '0) ? WIDTH'(1) : seed;
  assign lfsr_nxt  = lfsr_step(lfsr_q);
  assign candidate = lfsr_nxt[OUT_W-1:0] & mask_q;
  assign bound_m1  = bound - OUT_W'(1);

  // Smear the top set bit of bound-1 downward into a contiguous mask.
  always_comb begin
    new_mask = '0;
    for (int i = 0; i < OUT_W; i++) begin
      new_mask[i] = |(bound_m1 >> i);
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    valid_d = valid_q;
    bound_d = bound_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (load_seed) begin
          lfsr_d = seed_fix;
        end else if (start && (bound != '0)) begin
          bound_d = bound;
          mask_d  = new_mask;
          state_d = DRAW;
        end
      end
      DRAW: begin
        lfsr_d = lfsr_nxt;
        if (candidate < bound_q) begin
          data_d  = candidate;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= seed_fix;
      data_q  <= '0;
      valid_q <= 1'b0;
      bound_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      bound_q <= bound_d;
      mask_q  <= mask_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign busy       = (state_q == DRAW) || (state_q == HOLD);
  assign lfsr_state = lfsr_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_lfsr_range_gen.sv
// Directed bench for lfsr_range_gen: each task drives one scenario and checks
// outputs 1 time unit after the rising edge against hand-derived values.
module tb_lfsr_range_gen;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] seed;
  logic        load_seed;
  logic        start;
  logic [7:0]  bound;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        busy;
  logic [15:0] lfsr_state;
  logic [1:0]  fsm_state;

  int n_cmp = 0;
  int n_err = 0;

  lfsr_range_gen dut (
    .clk        (clk),
    .reset      (reset),
    .seed       (seed),
    .load_seed  (load_seed),
    .start      (start),
    .bound      (bound),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .busy       (busy),
    .lfsr_state (lfsr_state),
    .fsm_state  (fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] s);
    seed  = s;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; seed = 16'h0000; load_seed = 1'b0; start = 1'b1;
    bound = 8'd5; out_ready = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; out_ready = 1'b0;
    n_cmp++; if (lfsr_state !== 16'h0001) begin n_err++; $display("FAIL reset_lfsr: got %h required %h", lfsr_state, 16'h0001); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h required 00", out_data); end
    n_cmp++; if (fsm_state !== S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d required %0d", fsm_state, S_IDLE); end
  endtask

  task automatic test_basic_draw();
    do_reset(16'hACE1);
    n_cmp++; if (lfsr_state !== 16'hACE1) begin n_err++; $display("FAIL basic_seed: got %h required ACE1", lfsr_state); end
    start = 1'b1; bound = 8'd8;
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b required 1", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b required 0", out_valid); end
    tick();
    n_cmp++; if (lfsr_state !== 16'hE270) begin n_err++; $display("FAIL basic_lfsr: got %h required E270", lfsr_state); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b required 1", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL basic_data: got %h required 00", out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_drop: got %b required 0", out_valid); end
    n_cmp++; if (fsm_state !== S_IDLE) begin n_err++; $display("FAIL basic_idle: got %0d required %0d", fsm_state, S_IDLE); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL basic_retain: got %h required 00", out_data); end
  endtask

  task automatic test_reject_and_hold();
    do_reset(16'h0006);
    start = 1'b1; bound = 8'd3;
    tick();
    start = 1'b0;
    tick();
    n_cmp++; if (lfsr_state !== 16'h0003) begin n_err++; $display("FAIL rej_lfsr1: got %h required 0003", lfsr_state); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rej_valid1: got %b required 0", out_valid); end
    n_cmp++; if (fsm_state !== S_DRAW) begin n_err++; $display("FAIL rej_state1: got %0d required %0d", fsm_state, S_DRAW); end
    tick();
    n_cmp++; if (lfsr_state !== 16'hB401) begin n_err++; $display("FAIL rej_lfsr2: got %h required B401", lfsr_state); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rej_valid2: got %b required 1", out_valid); end
    n_cmp++; if (out_data !== 8'h01) begin n_err++; $display("FAIL rej_data: got %h required 01", out_data); end
    // stall in HOLD: starts and a seed load must have no effect
    for (int i = 0; i < 5; i++) begin
      start = i[0]; bound = 8'd7;
      load_seed = (i == 2); seed = 16'h5555;
      tick();
      n_cmp++; if (out_data !== 8'h01) begin n_err++; $display("FAIL hold_data[%0d]: got %h required 01", i, out_data); end
      n_cmp++; if (lfsr_state !== 16'hB401) begin n_err++; $display("FAIL hold_lfsr[%0d]: got %h required B401", i, lfsr_state); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d]: got %b required 1", i, out_valid); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL hold_busy[%0d]: got %b required 1", i, busy); end
    end
    start = 1'b0; load_seed = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_drop: got %b required 0", out_valid); end
    n_cmp++; if (fsm_state !== S_IDLE) begin n_err++; $display("FAIL hold_idle: got %0d required %0d", fsm_state, S_IDLE); end
    n_cmp++; if (out_data !== 8'h01) begin n_err++; $display("FAIL hold_retain: got %h required 01", out_data); end
  endtask

  task automatic test_bound_edges();
    // lfsr is B401 here; bound=0 must be ignored
    start = 1'b1; bound = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b0_busy[%0d]: got %b required 0", i, busy); end
      n_cmp++; if (lfsr_state !== 16'hB401) begin n_err++; $display("FAIL b0_lfsr[%0d]: got %h required B401", i, lfsr_state); end
    end
    bound = 8'd1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++; if (lfsr_state !== 16'hEE00) begin n_err++; $display("FAIL b1_lfsr: got %h required EE00", lfsr_state); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b1_valid: got %b required 1", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL b1_data: got %h required 00", out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_load_seed();
    seed = 16'h00C3; load_seed = 1'b1; start = 1'b1; bound = 8'd5;
    tick();
    load_seed = 1'b0; start = 1'b0;
    n_cmp++; if (lfsr_state !== 16'h00C3) begin n_err++; $display("FAIL ld_lfsr: got %h required 00C3", lfsr_state); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ld_busy: got %b required 0", busy); end
    seed = 16'h0000; load_seed = 1'b1;
    tick();
    load_seed = 1'b0;
    n_cmp++; if (lfsr_state !== 16'h0001) begin n_err++; $display("FAIL ld_zero: got %h required 0001", lfsr_state); end
  endtask

  task automatic test_reset_mid_draw();
    seed = 16'h0006; load_seed = 1'b1;
    tick();
    load_seed = 1'b0; start = 1'b1; bound = 8'd3;
    tick();
    start = 1'b0;
    tick();
    n_cmp++; if (fsm_state !== S_DRAW) begin n_err++; $display("FAIL mid_in_draw: got %0d required %0d", fsm_state, S_DRAW); end
    seed = 16'h1234; reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (lfsr_state !== 16'h1234) begin n_err++; $display("FAIL mid_lfsr: got %h required 1234", lfsr_state); end
    n_cmp++; if (fsm_state !== S_IDLE) begin n_err++; $display("FAIL mid_state: got %0d required %0d", fsm_state, S_IDLE); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid[%0d]: got %b required 0", i, out_valid); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    do_reset(16'hACE1);
    start = 1'b1; bound = 8'd200;
    tick();
    start = 1'b0;
    tick();
    n_cmp++; if (out_data !== 8'h70) begin n_err++; $display("FAIL b2b_data1: got %h required 70", out_data); end
    // start during the handshake edge is ignored; held start then wins in IDLE
    out_ready = 1'b1; start = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (fsm_state !== S_IDLE) begin n_err++; $display("FAIL b2b_idle: got %0d required %0d", fsm_state, S_IDLE); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drop: got %b required 0", out_valid); end
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b required 1", busy); end
    n_cmp++; if (lfsr_state !== 16'hE270) begin n_err++; $display("FAIL b2b_nostep: got %h required E270", lfsr_state); end
    tick();
    n_cmp++; if (lfsr_state !== 16'h7138) begin n_err++; $display("FAIL b2b_lfsr2: got %h required 7138", lfsr_state); end
    n_cmp++; if (out_data !== 8'h38) begin n_err++; $display("FAIL b2b_data2: got %h required 38", out_data); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid2: got %b required 1", out_valid); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_draw();
    test_reject_and_hold();
    test_bound_edges();
    test_load_seed();
    test_reset_mid_draw();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
